axi4_slave_ram: RTL and testbench

Synthesizable AXI4 full slave backed by a word-addressed RAM. It is the downstream consumer of the AXI4 master BFM and is instantiated through an axi4_if connector in place of the slave BFM. It gives RTL-level bursts and handshakes so that master-side benches run against real cycle behaviour. There is one outstanding write and one outstanding read, each with its own FSM.

---
 rtl/axi4_slave_ram_if.sv | 59 +++++
 rtl/axi4_slave_ram.sv | 219 +++++++++++++++++++++
 tb/tb_axi4_slave_ram.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_slave_ram_if.sv
// AXI4 connector carrying the address, data and response channels between a
// master and axi4_slave_ram. Sideband signals (cache, prot, lock, region, qos,
// user) are not carried.
interface axi4_slave_ram_if #(
    parameter int DATA_BYTES    = 4,
    parameter int ADDR_BYTES    = 1,
    parameter int NUM_ID_BITS_P = 4
) ();
    // write address channel
    logic                     awvalid;
    logic                     awready;
    logic [ADDR_BYTES*8-1:0]  awaddr;
    logic [7:0]               awlen;
    logic [2:0]               awsize;
    logic [1:0]               awburst;
    logic [NUM_ID_BITS_P-1:0] awid;
    // write data channel
    logic                     wvalid;
    logic                     wready;
    logic [DATA_BYTES*8-1:0]  wdata;
    logic [DATA_BYTES-1:0]    wstrb;
    logic                     wlast;
    // write response channel
    logic                     bvalid;
    logic                     bready;
    logic [1:0]               bresp;
    logic [NUM_ID_BITS_P-1:0] bid;
    // read address channel
    logic                     arvalid;
    logic                     arready;
    logic [ADDR_BYTES*8-1:0]  araddr;
    logic [7:0]               arlen;
    logic [2:0]               arsize;
    logic [1:0]               arburst;
    logic [NUM_ID_BITS_P-1:0] arid;
    // read data channel
    logic                     rvalid;
    logic                     rready;
    logic [DATA_BYTES*8-1:0]  rdata;
    logic [1:0]               rresp;
    logic [NUM_ID_BITS_P-1:0] rid;
    logic                     rlast;

    modport master (
        output awvalid, awaddr, awlen, awsize, awburst, awid,
        output wvalid, wdata, wstrb, wlast, bready,
        output arvalid, araddr, arlen, arsize, arburst, arid, rready,
        input  awready, wready, bvalid, bresp, bid,
        input  arready, rvalid, rdata, rresp, rid, rlast
    );

    modport slave (
        input  awvalid, awaddr, awlen, awsize, awburst, awid,
        input  wvalid, wdata, wstrb, wlast, bready,
        input  arvalid, araddr, arlen, arsize, arburst, arid, rready,
        output awready, wready, bvalid, bresp, bid,
        output arready, rvalid, rdata, rresp, rid, rlast
    );
endinterface

// File: rtl/axi4_slave_ram.sv
// AXI4 full slave backed by a word-addressed RAM. One outstanding write and one
// outstanding read, each handled by its own FSM; the two run concurrently.
module axi4_slave_ram #(
    parameter int DATA_BYTES    = 4,
    parameter int ADDR_BYTES    = 1,
    parameter int NUM_ID_BITS_P = 4,
    parameter int MEM_DEPTH     = 64
) (
    input logic             aclk,
    input logic             areset,
    axi4_slave_ram_if.slave bus
);
    localparam int DATA_W = DATA_BYTES * 8;
    localparam int ADDR_W = ADDR_BYTES * 8;
    localparam int BSHIFT = $clog2(DATA_BYTES);
    localparam int WORD_W = $clog2(MEM_DEPTH);
    localparam int XW     = ADDR_W + 16;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    // RAM word selected by a byte address; wraps modulo the RAM depth
    function automatic logic [WORD_W-1:0] word_of(input logic [ADDR_W-1:0] a);
        return WORD_W'(a >> BSHIFT);
    endfunction

    // oversize beats, reserved burst type and WRAP with a non-power-of-two length
    function automatic logic bad_burst(input logic [7:0] len, input logic [2:0] size,
                                       input logic [1:0] burst);
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (size > 3'(BSHIFT)) || (burst == 2'b11) || ((burst == 2'b10) && !wrap_len_ok);
    endfunction

    // byte address of the following beat for FIXED / INCR / WRAP bursts
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                    input logic [7:0] len,
                                                    input logic [2:0] size,
                                                    input logic [1:0] burst);
        logic [XW-1:0] step, span, sum, base;
        step = XW'(1) << size;
        span = (XW'(len) + XW'(1)) << size;
        sum  = XW'(a) + step;
        base = XW'(a) & ~(span - XW'(1));
        case (burst)
            2'b00:   return a;
            2'b10:   return ADDR_W'(base | (sum & (span - XW'(1))));
            default: return ADDR_W'(sum);
        endcase
    endfunction

    logic alive;

    // outputs stay low during reset; ready appears on the first edge after release
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) alive <= 1'b0;
        else        alive <= 1'b1;
    end

    // ---------------- write path ----------------
    wstate_t                  w_state, w_next;
    logic [ADDR_W-1:0]        w_addr;
    logic [7:0]               w_len, w_cnt;
    logic [2:0]               w_size;
    logic [1:0]               w_burst;
    logic [NUM_ID_BITS_P-1:0] w_id;
    logic                     w_err, w_last_err;
    logic                     awready_c, wready_c, bvalid_c, aw_hs, w_hs;

    // write FSM state register
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) w_state <= W_IDLE;
        else        w_state <= w_next;
    end

    // write FSM next state and channel handshake outputs
    always_comb begin
        w_next    = w_state;
        awready_c = 1'b0;
        wready_c  = 1'b0;
        bvalid_c  = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                awready_c = alive;
                if (bus.awvalid && alive) w_next = W_DATA;
            end
            W_DATA: begin
                wready_c = 1'b1;
                if (bus.wvalid && (w_cnt == w_len)) w_next = W_RESP;
            end
            W_RESP: begin
                bvalid_c = 1'b1;
                if (bus.bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    assign aw_hs = bus.awvalid && awready_c;
    assign w_hs  = bus.wvalid && wready_c;

    // capture the write command, then walk the burst address and flag wlast misuse
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_addr     <= '0;
            w_len      <= '0;
            w_cnt      <= '0;
            w_size     <= '0;
            w_burst    <= '0;
            w_id       <= '0;
            w_err      <= 1'b0;
            w_last_err <= 1'b0;
        end else if (aw_hs) begin
            w_addr     <= bus.awaddr;
            w_len      <= bus.awlen;
            w_cnt      <= '0;
            w_size     <= bus.awsize;
            w_burst    <= bus.awburst;
            w_id       <= bus.awid;
            w_err      <= bad_burst(bus.awlen, bus.awsize, bus.awburst);
            w_last_err <= 1'b0;
        end else if (w_hs) begin
            w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
            w_cnt  <= w_cnt + 8'd1;
            if (bus.wlast != (w_cnt == w_len)) w_last_err <= 1'b1;
        end
    end

    // strobed byte writes; an erroring burst leaves the RAM untouched
    always_ff @(posedge aclk) begin
        if (w_hs && !w_err) begin
            for (int b = 0; b < DATA_BYTES; b++) begin
                if (bus.wstrb[b]) mem[word_of(w_addr)][b*8 +: 8] <= bus.wdata[b*8 +: 8];
            end
        end
    end

    assign bus.awready = awready_c;
    assign bus.wready  = wready_c;
    assign bus.bvalid  = bvalid_c;
    assign bus.bresp   = (bvalid_c && (w_err || w_last_err)) ? 2'b10 : 2'b00;
    assign bus.bid     = bvalid_c ? w_id : '0;

    // ---------------- read path ----------------
    rstate_t                  r_state, r_next;
    logic [ADDR_W-1:0]        r_addr;
    logic [7:0]               r_len, r_cnt;
    logic [2:0]               r_size;
    logic [1:0]               r_burst;
    logic [NUM_ID_BITS_P-1:0] r_id;
    logic                     r_err, ar_err;
    logic [DATA_W-1:0]        rdata_q;
    logic                     arready_c, rvalid_c, ar_hs, r_hs;

    // read FSM state register
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) r_state <= R_IDLE;
        else        r_state <= r_next;
    end

    // read FSM next state and channel handshake outputs
    always_comb begin
        r_next    = r_state;
        arready_c = 1'b0;
        rvalid_c  = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                arready_c = alive;
                if (bus.arvalid && alive) r_next = R_DATA;
            end
            R_DATA: begin
                rvalid_c = 1'b1;
                if (bus.rready && (r_cnt == r_len)) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    assign ar_hs  = bus.arvalid && arready_c;
    assign r_hs   = rvalid_c && bus.rready;
    assign ar_err = bad_burst(bus.arlen, bus.arsize, bus.arburst);

    // preload each beat's data so accepted beats stream back-to-back; a same-edge
    // RAM write is not visible here, so the read sees the old word
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_id    <= '0;
            r_err   <= 1'b0;
            rdata_q <= '0;
        end else if (ar_hs) begin
            r_addr  <= next_addr(bus.araddr, bus.arlen, bus.arsize, bus.arburst);
            r_len   <= bus.arlen;
            r_cnt   <= '0;
            r_size  <= bus.arsize;
            r_burst <= bus.arburst;
            r_id    <= bus.arid;
            r_err   <= ar_err;
            rdata_q <= ar_err ? '0 : mem[word_of(bus.araddr)];
        end else if (r_hs && (r_cnt != r_len)) begin
            r_addr  <= next_addr(r_addr, r_len, r_size, r_burst);
            r_cnt   <= r_cnt + 8'd1;
            rdata_q <= r_err ? '0 : mem[word_of(r_addr)];
        end
    end

    assign bus.arready = arready_c;
    assign bus.rvalid  = rvalid_c;
    assign bus.rdata   = rvalid_c ? rdata_q : '0;
    assign bus.rresp   = (rvalid_c && r_err) ? 2'b10 : 2'b00;
    assign bus.rid     = rvalid_c ? r_id : '0;
    assign bus.rlast   = rvalid_c && (r_cnt == r_len);
endmodule

// File: tb/tb_axi4_slave_ram.sv
// Testbench for axi4_slave_ram: directed bursts plus random transactions,
// checked against a byte-level memory model of the slave.
module tb_axi4_slave_ram;
    localparam int DATA_BYTES    = 4;
    localparam int ADDR_BYTES    = 1;
    localparam int NUM_ID_BITS_P = 4;
    localparam int MEM_DEPTH     = 64;

    logic aclk   = 1'b0;
    logic areset = 1'b1;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [31:0] model    [MEM_DEPTH];
    logic [31:0] beatData [256];
    logic [3:0]  beatStrb [256];
    logic [31:0] oldWord, newWord;
    int          waitCount;

    axi4_slave_ram_if #(
        .DATA_BYTES(DATA_BYTES), .ADDR_BYTES(ADDR_BYTES), .NUM_ID_BITS_P(NUM_ID_BITS_P)
    ) bus ();

    axi4_slave_ram #(
        .DATA_BYTES(DATA_BYTES), .ADDR_BYTES(ADDR_BYTES),
        .NUM_ID_BITS_P(NUM_ID_BITS_P), .MEM_DEPTH(MEM_DEPTH)
    ) dut (
        .aclk  (aclk),
        .areset(areset),
        .bus   (bus)
    );

    // free-running 100 MHz clock
    always #5 aclk = ~aclk;

    // safety net in case the DUT stalls in a way the bounded waits miss
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // word touched by beat 'beat' of a burst, straight from the address rules
    function automatic int beatWord(int addr, int len, int size, int burst, int beat);
        int step, span, base, a;
        step = 1 << size;
        case (burst)
            0: a = addr;
            2: begin
                span = (len + 1) * step;
                base = addr - (addr % span);
                a    = base + ((addr - base + beat * step) % span);
            end
            default: a = addr + beat * step;
        endcase
        return (a / DATA_BYTES) % MEM_DEPTH;
    endfunction

    function automatic bit isBad(int len, int size, int burst);
        return (size > $clog2(DATA_BYTES)) || (burst == 3) ||
               ((burst == 2) && !(len == 1 || len == 3 || len == 7 || len == 15));
    endfunction

    task automatic writeBurst(input int addr, input int len, input int size, input int burst,
                              input int id, input int lastAt, input bit gaps);
        int  t, d, w;
        bit  bad;
        int  expResp;
        bad     = isBad(len, size, burst);
        expResp = (bad || lastAt != len) ? 2 : 0;
        @(posedge aclk); #1;
        bus.awvalid = 1'b1;
        bus.awaddr  = 8'(addr);
        bus.awlen   = 8'(len);
        bus.awsize  = 3'(size);
        bus.awburst = 2'(burst);
        bus.awid    = 4'(id);
        t = 0;
        @(negedge aclk);
        while (bus.awready !== 1'b1 && t < 20) begin @(negedge aclk); t++; end
        checkOutput("awready_wait", 64'(bus.awready), 64'(1));
        @(posedge aclk); #1;
        bus.awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            if (gaps) begin
                d = $urandom_range(0, 2);
                bus.wvalid = 1'b0;
                repeat (d) begin @(posedge aclk); #1; end
            end
            bus.wvalid = 1'b1;
            bus.wdata  = beatData[i];
            bus.wstrb  = beatStrb[i];
            bus.wlast  = (i == lastAt);
            t = 0;
            @(negedge aclk);
            while (bus.wready !== 1'b1 && t < 20) begin @(negedge aclk); t++; end
            checkOutput("wready_wait", 64'(bus.wready), 64'(1));
            @(posedge aclk); #1;
            if (!bad) begin
                w = beatWord(addr, len, size, burst, i);
                for (int b = 0; b < DATA_BYTES; b++)
                    if (beatStrb[i][b]) model[w][b*8 +: 8] = beatData[i][b*8 +: 8];
            end
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        d = gaps ? $urandom_range(0, 2) : 0;
        bus.bready = (d == 0);
        @(negedge aclk);
        checkOutput("bvalid", 64'(bus.bvalid), 64'(1));
        checkOutput("bresp", 64'(bus.bresp), 64'(expResp));
        checkOutput("bid", 64'(bus.bid), 64'(id));
        for (int k = 0; k < d; k++) begin
            @(posedge aclk); #1;
            if (k == d - 1) bus.bready = 1'b1;
            @(negedge aclk);
            checkOutput("bvalid_hold", 64'(bus.bvalid), 64'(1));
            checkOutput("bid_hold", 64'(bus.bid), 64'(id));
        end
        @(posedge aclk); #1;
        bus.bready = 1'b0;
        @(negedge aclk);
        checkOutput("bvalid_drop", 64'(bus.bvalid), 64'(0));
    endtask

    task automatic readBurst(input int addr, input int len, input int size, input int burst,
                             input int id, input bit stream);
        int          t, g;
        bit          bad;
        logic [31:0] exp;
        bad = isBad(len, size, burst);
        @(posedge aclk); #1;
        bus.arvalid = 1'b1;
        bus.araddr  = 8'(addr);
        bus.arlen   = 8'(len);
        bus.arsize  = 3'(size);
        bus.arburst = 2'(burst);
        bus.arid    = 4'(id);
        t = 0;
        @(negedge aclk);
        while (bus.arready !== 1'b1 && t < 20) begin @(negedge aclk); t++; end
        checkOutput("arready_wait", 64'(bus.arready), 64'(1));
        @(posedge aclk); #1;
        bus.arvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            exp = bad ? 32'h0 : model[beatWord(addr, len, size, burst, i)];
            g = stream ? 0 : $urandom_range(0, 2);
            bus.rready = 1'b0;
            repeat (g) begin
                @(negedge aclk);
                checkOutput("rvalid_stall", 64'(bus.rvalid), 64'(1));
                checkOutput("rdata_stall", 64'(bus.rdata), 64'(exp));
                @(posedge aclk); #1;
            end
            bus.rready = 1'b1;
            @(negedge aclk);
            checkOutput("rvalid", 64'(bus.rvalid), 64'(1));
            checkOutput("rdata", 64'(bus.rdata), 64'(exp));
            checkOutput("rresp", 64'(bus.rresp), bad ? 64'(2) : 64'(0));
            checkOutput("rid", 64'(bus.rid), 64'(id));
            checkOutput("rlast", 64'(bus.rlast), 64'(i == len));
            @(posedge aclk); #1;
        end
        bus.rready = 1'b0;
        @(negedge aclk);
        checkOutput("rvalid_drop", 64'(bus.rvalid), 64'(0));
    endtask

    // one random read or write with random burst shape, strobes and stalls
    task automatic applyStimulus();
        int addr, len, size, burst, id;
        int lens [4] = '{1, 3, 7, 15};
        addr  = $urandom_range(0, 255);
        burst = $urandom_range(0, 2);
        if ($urandom_range(0, 9) == 0) burst = 3;
        size = $urandom_range(0, 2);
        if ($urandom_range(0, 9) == 0) size = 3;
        if (burst == 2) begin
            len = lens[$urandom_range(0, 3)];
            if ($urandom_range(0, 7) == 0) len = $urandom_range(0, 15);
        end else begin
            len = $urandom_range(0, 7);
        end
        id = $urandom_range(0, 15);
        if ($urandom_range(0, 1) == 1) begin
            for (int i = 0; i <= len; i++) begin
                beatData[i] = $urandom;
                beatStrb[i] = 4'($urandom_range(0, 15));
            end
            writeBurst(addr, len, size, burst, id, len, 1'b1);
        end else begin
            readBurst(addr, len, size, burst, id, 1'b0);
        end
    endtask

    initial begin
        bus.awvalid = 1'b0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0;
        bus.awburst = '0;   bus.awid   = '0;
        bus.wvalid  = 1'b0; bus.wdata  = '0; bus.wstrb = '0; bus.wlast  = 1'b0;
        bus.bready  = 1'b0;
        bus.arvalid = 1'b0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0;
        bus.arburst = '0;   bus.arid   = '0;
        bus.rready  = 1'b0;

        // reset state and ready release
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        checkOutput("reset_awready", 64'(bus.awready), 64'(0));
        checkOutput("reset_arready", 64'(bus.arready), 64'(0));
        checkOutput("reset_wready", 64'(bus.wready), 64'(0));
        checkOutput("reset_bvalid", 64'(bus.bvalid), 64'(0));
        checkOutput("reset_rvalid", 64'(bus.rvalid), 64'(0));
        @(posedge aclk); #1;
        areset = 1'b0;
        @(negedge aclk);
        checkOutput("awready_before_edge", 64'(bus.awready), 64'(0));
        @(negedge aclk);
        checkOutput("awready_after_edge", 64'(bus.awready), 64'(1));
        checkOutput("arready_after_edge", 64'(bus.arready), 64'(1));

        // give every RAM word a known value
        for (int i = 0; i < MEM_DEPTH; i++) begin
            beatData[i] = $urandom;
            beatStrb[i] = 4'hF;
        end
        writeBurst(0, MEM_DEPTH - 1, 2, 1, 0, MEM_DEPTH - 1, 1'b0);

        // single-beat write and read-back
        beatData[0] = 32'hDEADBEEF; beatStrb[0] = 4'hF;
        writeBurst(8'h10, 0, 2, 1, 3, 0, 1'b0);
        readBurst(8'h10, 0, 2, 1, 3, 1'b1);

        // INCR burst, partial-strobe overwrite, streamed read-back
        for (int i = 0; i < 4; i++) begin
            beatData[i] = 32'(i + 1);
            beatStrb[i] = 4'hF;
        end
        writeBurst(8'h08, 3, 2, 1, 5, 3, 1'b0);
        beatData[0] = 32'hAAAAAAAA; beatStrb[0] = 4'h3;
        writeBurst(8'h08, 0, 2, 1, 6, 0, 1'b0);
        readBurst(8'h08, 3, 2, 1, 7, 1'b1);

        // WRAP ordering and illegal WRAP length
        readBurst(8'h38, 3, 2, 2, 1, 1'b1);
        readBurst(8'h38, 2, 2, 2, 2, 1'b0);

        // oversize write is dropped; early wlast still writes all beats
        beatData[0] = 32'h12345678; beatStrb[0] = 4'hF;
        writeBurst(8'h20, 0, 3, 1, 4, 0, 1'b0);
        readBurst(8'h20, 0, 2, 1, 4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            beatData[i] = $urandom;
            beatStrb[i] = 4'hF;
        end
        writeBurst(8'h40, 3, 2, 1, 9, 1, 1'b0);
        readBurst(8'h40, 3, 2, 1, 9, 1'b1);

        // write beat and read address on the same edge to the same word
        oldWord = model[12];
        newWord = ~oldWord;
        @(posedge aclk); #1;
        bus.awvalid = 1'b1; bus.awaddr = 8'h30; bus.awlen = 8'd0; bus.awsize = 3'd2;
        bus.awburst = 2'd1; bus.awid = 4'd2;
        waitCount = 0;
        @(negedge aclk);
        while (bus.awready !== 1'b1 && waitCount < 20) begin @(negedge aclk); waitCount++; end
        checkOutput("rbw_awready", 64'(bus.awready), 64'(1));
        @(posedge aclk); #1;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b1; bus.wdata = newWord; bus.wstrb = 4'hF; bus.wlast = 1'b1;
        bus.arvalid = 1'b1; bus.araddr = 8'h30; bus.arlen = 8'd0; bus.arsize = 3'd2;
        bus.arburst = 2'd1; bus.arid = 4'd2;
        @(negedge aclk);
        checkOutput("rbw_wready", 64'(bus.wready), 64'(1));
        checkOutput("rbw_arready", 64'(bus.arready), 64'(1));
        @(posedge aclk); #1;
        bus.wvalid = 1'b0; bus.wlast = 1'b0; bus.arvalid = 1'b0;
        bus.rready = 1'b1; bus.bready = 1'b1;
        @(negedge aclk);
        checkOutput("rbw_rvalid", 64'(bus.rvalid), 64'(1));
        checkOutput("rbw_old_data", 64'(bus.rdata), 64'(oldWord));
        checkOutput("rbw_bvalid", 64'(bus.bvalid), 64'(1));
        checkOutput("rbw_bresp", 64'(bus.bresp), 64'(0));
        @(posedge aclk); #1;
        bus.rready = 1'b0; bus.bready = 1'b0;
        model[12] = newWord;
        @(negedge aclk);
        checkOutput("rbw_rvalid_drop", 64'(bus.rvalid), 64'(0));
        checkOutput("rbw_bvalid_drop", 64'(bus.bvalid), 64'(0));
        readBurst(8'h30, 0, 2, 1, 2, 1'b1);

        // reset in the middle of a long read
        @(posedge aclk); #1;
        bus.arvalid = 1'b1; bus.araddr = 8'h00; bus.arlen = 8'd7; bus.arsize = 3'd2;
        bus.arburst = 2'd1; bus.arid = 4'd5;
        waitCount = 0;
        @(negedge aclk);
        while (bus.arready !== 1'b1 && waitCount < 20) begin @(negedge aclk); waitCount++; end
        checkOutput("rst_arready", 64'(bus.arready), 64'(1));
        @(posedge aclk); #1;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b1;
        @(posedge aclk); #1;
        @(posedge aclk); #1;
        @(negedge aclk);
        checkOutput("rst_beat2_rvalid", 64'(bus.rvalid), 64'(1));
        checkOutput("rst_beat2_rdata", 64'(bus.rdata), 64'(model[2]));
        areset = 1'b1;
        #1;
        checkOutput("rst_rvalid_now", 64'(bus.rvalid), 64'(0));
        checkOutput("rst_rlast_now", 64'(bus.rlast), 64'(0));
        checkOutput("rst_arready_now", 64'(bus.arready), 64'(0));
        bus.rready = 1'b0;
        @(posedge aclk); #1;
        areset = 1'b0;
        @(negedge aclk);
        checkOutput("rst_arready_released", 64'(bus.arready), 64'(0));
        @(negedge aclk);
        checkOutput("rst_arready_back", 64'(bus.arready), 64'(1));
        checkOutput("rst_rvalid_idle", 64'(bus.rvalid), 64'(0));
        readBurst(8'h00, 7, 2, 1, 5, 1'b0);

        // random traffic against the model
        repeat (40) applyStimulus();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
